vga_square_renderer: RTL and testbench
======================================

Name: vga_square_renderer

Overview:
- Pixel source directly upstream of the VGA output controller.
- Consumes the controller's linear pixel address (ADDR, 19 bits, 640x480 raster, increments by 1 per active pixel, forced to 0 during vsync) and returns 24-bit RGB for that pixel.
- Draws a solid movable square over a flat background. The square is moved by four direction inputs, with moves applied once per frame at frame start.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- SQ_SIZE, 32, square edge length in pixels
- STEP, 4, pixels moved per frame per pending direction
- SQ_COLOR, 24'hFF0000, square colour {R,G,B}
- BG_COLOR, 24'h000040, background colour {R,G,B}

Ports:
- iVGA_CLK  in  1  pixel clock; the only clock
- iRST_n  in  1  asynchronous active-low reset
- ADDR  in  19  linear pixel address from the VGA controller
- btn_up  in  1  level, synchronous to iVGA_CLK, pre-debounced
- btn_down  in  1  as above
- btn_left  in  1  as above
- btn_right  in  1  as above
- rgb_data_raw  out  24  pixel colour {R[23:16],G[15:8],B[7:0]}, registered
- sq_x  out  10  current square left edge
- sq_y  out  9  current square top edge
- frame_tick  out  1  one-cycle pulse at frame start

Behaviour:
- Reset (async, iRST_n=0). All state clears immediately, including mid-frame:
  - addr_q=0, x=0, y=0
  - rgb_data_raw=0, frame_tick=0
  - sq_x=(H_ACTIVE-SQ_SIZE)/2=304, sq_y=(V_ACTIVE-SQ_SIZE)/2=224
  - pending flags=0
- Pixel tracking, evaluated at every rising edge, in priority order:
  - addr_q <= ADDR on every edge.
  - ADDR==0: x<=0, y<=0.
  - Else if ADDR!=addr_q (step): if x==H_ACTIVE-1 then x<=0 and y<=y+1, with y saturating at V_ACTIVE-1; otherwise x<=x+1.
  - Else: hold.
- Frame tick:
  - frame_tick <= (ADDR==0 && addr_q!=0), a registered single-cycle pulse.
  - No tick is generated out of reset until ADDR has been nonzero at least once.
- Pending moves:
  - Each pending flag sets while its btn is high.
  - A btn high in the tick-detect cycle is included in that frame's update.
  - All pending flags clear in the cycle the update is applied.
- Square update, in the cycle frame_tick is registered high:
  - Horizontal: right-only pending gives sq_x+STEP, left-only gives sq_x-STEP, both or neither gives no change.
  - Vertical: same rule with down/up on sq_y.
  - Clamp sq_x to [0, H_ACTIVE-SQ_SIZE=608] and sq_y to [0, V_ACTIVE-SQ_SIZE=448].
  - Compute the result at 11/10 bits signed-safe width, then clamp; no wrap-around.
- Colour:
  - rgb_data_raw <= SQ_COLOR when sq_x<=x<sq_x+SQ_SIZE and sq_y<=y<sq_y+SQ_SIZE; otherwise BG_COLOR.
  - Compare at 11/10 bits so sq_x+SQ_SIZE does not overflow.
- Latency:
  - An ADDR value sampled at edge k produces rgb_data_raw after edge k+1.
  - Net display offset is 2 pixels right; this is accepted and not compensated.
  - The square position changes only between frames, so there is no tearing.
- The controller latches rgb_data_raw on the falling edge. The output must come from a flop with no combinational path from ADDR.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults
  - X_W=10, Y_W=9, ADDR_W=19, RGB_W=24
  - colour constants SQ_COLOR/BG_COLOR defaults
- Sub-module vga_pixel_tracker:
  - Inputs: ADDR, iVGA_CLK, iRST_n.
  - Outputs: x, y, frame_tick.
  - Implements the addr_q/x/y/tick logic.
- Top-level vga_square_renderer holds the pending flags, square position register and colour register.

Test Plan:
- Reset then raster:
  - Stimulus: drive ADDR 0..307199 (+1/cycle), then hold, then 0.
  - Required: rgb=BG_COLOR except pixels x in [304,335], y in [224,255], which are SQ_COLOR, 2 cycles after their ADDR. Exactly one frame_tick at the return to 0.
- Move right:
  - Stimulus: btn_right high for 3 cycles mid-frame.
  - Required: after the next tick, sq_x=308 and sq_y=224; the next frame shows the square at x 308..339.
- Opposing buttons:
  - Stimulus: btn_left and btn_right both pulsed in one frame.
  - Required: sq_x unchanged at 304. Also, btn_up held for 60 frames gives sq_y clamped at 0, never wrapping to 448+.
- Right clamp:
  - Stimulus: sq_x driven to 608, then btn_right.
  - Required: sq_x stays 608, and the pixel at x=639 is SQ_COLOR.
- Tick-cycle button and reset mid-frame:
  - Stimulus A: btn_down high only in the ADDR==0 detect cycle. Required: sq_y=228 after the tick.
  - Stimulus B: assert iRST_n=0 at ADDR=150000. Required: rgb=0, sq_x=304, sq_y=224 immediately; no frame_tick until ADDR has been nonzero again.
- Line wrap:
  - Stimulus: ADDR 639→640.
  - Required: x goes 639→0 and y increments. ADDR held constant over 10 cycles leaves x/y unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared widths, raster defaults and colours for the square renderer.
// Latency: n/a (declarations and one pure function).
// Backpressure: n/a.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int ADDR_W = 19;
  localparam int RGB_W  = 24;

  // Width used for position arithmetic so x+size and x-step never wrap.
  localparam int POS_W  = 11;

  localparam logic [RGB_W-1:0] SQ_COLOR_DEF = 24'hFF0000;
  localparam logic [RGB_W-1:0] BG_COLOR_DEF = 24'h000040;

  // Pending direction requests collected across a frame.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } move_t;

  // Move pos by +step (inc only) or -step (dec only), then clamp to [0, lim].
  // One guard bit above POS_W acts as the sign, so underflow clamps to 0.
  function automatic logic [POS_W-1:0] step_clamp(
    input logic [POS_W-1:0] pos,
    input logic             inc,
    input logic             dec,
    input logic [POS_W-1:0] step,
    input logic [POS_W-1:0] lim
  );
    logic [POS_W:0] n;
    n = {1'b0, pos};
    if (inc && !dec) begin
      n = n + {1'b0, step};
    end else if (dec && !inc) begin
      n = n - {1'b0, step};
    end
    if (n[POS_W]) begin
      step_clamp = '0;
    end else if (n[POS_W-1:0] > lim) begin
      step_clamp = lim;
    end else begin
      step_clamp = n[POS_W-1:0];
    end
  endfunction

endpackage

// File: rtl/vga_pixel_tracker.sv
// Recovers raster x/y from the controller's linear address and flags frame start.
// Latency: x/y/frame_tick valid one cycle after the ADDR that produced them.
// Backpressure: none; follows ADDR every pixel clock.
module vga_pixel_tracker
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              frame_tick
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [ADDR_W-1:0] addr_q;

  // Address history and frame-start pulse; addr_q resets to 0 so no tick
  // fires after reset until the address has left 0 at least once.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr_q     <= '0;
      frame_tick <= 1'b0;
    end else begin
      addr_q     <= ADDR;
      frame_tick <= (ADDR == '0) && (addr_q != '0);
    end
  end

  // Position counters: restart at address 0, advance on any address change,
  // hold while the address is held (blanking). y saturates on the last line.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x <= '0;
      y <= '0;
    end else if (ADDR == '0) begin
      x <= '0;
      y <= '0;
    end else if (ADDR != addr_q) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y != Y_LAST) begin
          y <= y + 1'b1;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_square_renderer.sv
// Pixel source drawing a button-movable solid square over a flat background.
// Latency: ADDR sampled at edge k gives rgb_data_raw after edge k+1 (flopped output).
// Backpressure: none; moves are queued as pending flags and applied once per frame.
module vga_square_renderer
  import vga_pkg::*;
#(
  parameter int               H_ACTIVE = H_ACTIVE_DEF,
  parameter int               V_ACTIVE = V_ACTIVE_DEF,
  parameter int               SQ_SIZE  = 32,
  parameter int               STEP     = 4,
  parameter logic [RGB_W-1:0] SQ_COLOR = SQ_COLOR_DEF,
  parameter logic [RGB_W-1:0] BG_COLOR = BG_COLOR_DEF
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  output logic [RGB_W-1:0]  rgb_data_raw,
  output logic [X_W-1:0]    sq_x,
  output logic [Y_W-1:0]    sq_y,
  output logic              frame_tick
);

  localparam logic [X_W-1:0]   SQ_X_INIT = X_W'((H_ACTIVE - SQ_SIZE) / 2);
  localparam logic [Y_W-1:0]   SQ_Y_INIT = Y_W'((V_ACTIVE - SQ_SIZE) / 2);
  localparam logic [POS_W-1:0] X_MAX     = POS_W'(H_ACTIVE - SQ_SIZE);
  localparam logic [POS_W-1:0] Y_MAX     = POS_W'(V_ACTIVE - SQ_SIZE);
  localparam logic [POS_W-1:0] STEP_W    = POS_W'(STEP);
  localparam logic [POS_W-1:0] SIZE_W    = POS_W'(SQ_SIZE);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  move_t          btn;
  move_t          pend;
  logic           in_x;
  logic           in_y;

  vga_pixel_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_tracker (
    .iVGA_CLK   (iVGA_CLK),
    .iRST_n     (iRST_n),
    .ADDR       (ADDR),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick)
  );

  assign btn = '{up: btn_up, down: btn_down, left: btn_left, right: btn_right};

  // Collect direction requests; the apply cycle clears them (and drops any
  // press in that single cycle), so each frame starts with a clean slate.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pend <= '0;
    end else if (frame_tick) begin
      pend <= '0;
    end else begin
      pend <= pend | btn;
    end
  end

  // Square position moves only in the cycle after frame start, so a frame
  // is always drawn with one position (no tearing).
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sq_x <= SQ_X_INIT;
      sq_y <= SQ_Y_INIT;
    end else if (frame_tick) begin
      sq_x <= X_W'(step_clamp({1'b0, sq_x}, pend.right, pend.left, STEP_W, X_MAX));
      sq_y <= Y_W'(step_clamp({2'b00, sq_y}, pend.down, pend.up, STEP_W, Y_MAX));
    end
  end

  // Square hit test, one bit wider than the coordinates so edge+size cannot wrap.
  always_comb begin
    in_x = 1'b0;
    in_y = 1'b0;
    in_x = ({1'b0, x} >= {1'b0, sq_x}) &&
           ({1'b0, x} < ({1'b0, sq_x} + SIZE_W));
    in_y = ({2'b00, y} >= {2'b00, sq_y}) &&
           ({2'b00, y} < ({2'b00, sq_y} + SIZE_W));
  end

  // Colour register: the controller samples on the falling edge, so the
  // output must come straight from a flop.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rgb_data_raw <= '0;
    end else begin
      rgb_data_raw <= (in_x && in_y) ? SQ_COLOR : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_vga_square_renderer.sv
module tb_vga_square_renderer;

  localparam int H    = 640;
  localparam int SQ   = 32;
  localparam int STEP = 4;
  localparam int XMAX = 608;
  localparam int YMAX = 448;
  localparam logic [23:0] SQC = 24'hFF0000;
  localparam logic [23:0] BGC = 24'h000040;

  // button vector bit order: {up, down, left, right}
  localparam logic [3:0] B_UP    = 4'b1000;
  localparam logic [3:0] B_DOWN  = 4'b0100;
  localparam logic [3:0] B_LEFT  = 4'b0010;
  localparam logic [3:0] B_RIGHT = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] addr;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [23:0] rgb;
  logic [9:0]  sq_x;
  logic [8:0]  sq_y;
  logic        frame_tick;

  vga_square_renderer dut (
    .iVGA_CLK     (clk),
    .iRST_n       (rst_n),
    .ADDR         (addr),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .rgb_data_raw (rgb),
    .sq_x         (sq_x),
    .sq_y         (sq_y),
    .frame_tick   (frame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] v; } exp_t;
  typedef struct { int due; int x; int y; } sq_exp_t;

  exp_t    rgb_q[$];
  exp_t    tick_q[$];
  sq_exp_t sq_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: square position, pending requests, last address.
  int         m_x = 304;
  int         m_y = 224;
  int         m_prev = 0;
  bit         m_skip = 0;
  logic [3:0] m_pend = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [23:0] pix_color(input int a);
    int px, py;
    px = a % H;
    py = a / H;
    if (px >= m_x && px < m_x + SQ && py >= m_y && py < m_y + SQ) return SQC;
    return BGC;
  endfunction

  task automatic model_apply();
    int dx, dy;
    dx = (m_pend[0] && !m_pend[1]) ? STEP : (m_pend[1] && !m_pend[0]) ? -STEP : 0;
    dy = (m_pend[2] && !m_pend[3]) ? STEP : (m_pend[3] && !m_pend[2]) ? -STEP : 0;
    m_x = clampi(m_x + dx, 0, XMAX);
    m_y = clampi(m_y + dy, 0, YMAX);
    m_pend = 4'd0;
  endtask

  task automatic model_reset();
    m_x = 304; m_y = 224; m_prev = 0; m_skip = 0; m_pend = 4'd0;
  endtask

  // One pixel clock of stimulus; expectations go to the scoreboard queues.
  task automatic drive(input int a, input logic [3:0] b, input bit chk);
    bit tk;
    @(negedge clk);
    addr = a[18:0];
    {btn_up, btn_down, btn_left, btn_right} = b;
    if (!m_skip) m_pend = m_pend | b;
    m_skip = 0;
    tk = (a == 0) && (m_prev != 0);
    if (tk) begin
      model_apply();
      m_skip = 1;
    end
    tick_q.push_back('{cyc + 1, 32'(tk)});
    if (chk) rgb_q.push_back('{cyc + 2, 32'(pix_color(a))});
    m_prev = a;
  endtask

  // Three blanking cycles at address 0, then pixels 1..npix. Buttons b are
  // held for pixels in [p0,p1) (p0==0 includes the later blanking cycles);
  // bz is driven in the first blanking (frame-start detect) cycle.
  task automatic run_frame(input int npix, input logic [3:0] bz, input logic [3:0] b,
                           input int p0, input int p1, input int hold_at, input bit chk);
    logic [3:0] bb;
    bb = (p0 == 0) ? b : 4'd0;
    drive(0, bz, 0);
    drive(0, bb, 0);
    drive(0, bb, 0);
    sq_q.push_back('{cyc + 2, m_x, m_y});
    for (int a = 1; a <= npix; a++) begin
      bb = (a >= p0 && a < p1) ? b : 4'd0;
      drive(a, bb, chk);
      if (a == hold_at) repeat (10) drive(a, bb, chk);
    end
  endtask

  // Monitor: compare whatever the scoreboard says is due at this cycle.
  exp_t    me;
  sq_exp_t ms;
  always @(negedge clk) begin
    while (rgb_q.size() > 0 && rgb_q[0].due <= cyc) begin
      me = rgb_q.pop_front();
      check("rgb", 32'(rgb), me.v);
    end
    while (tick_q.size() > 0 && tick_q[0].due <= cyc) begin
      me = tick_q.pop_front();
      check("frame_tick", 32'(frame_tick), me.v);
    end
    while (sq_q.size() > 0 && sq_q[0].due <= cyc) begin
      ms = sq_q.pop_front();
      check("sq_x", 32'(sq_x), ms.x);
      check("sq_y", 32'(sq_y), ms.y);
    end
  end

  logic [3:0] rz, rb;
  int len, p0, p1;

  initial begin
    rst_n = 1'b1;
    addr = '0;
    {btn_up, btn_down, btn_left, btn_right} = 4'd0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_rgb", 32'(rgb), 0);
    check("reset_sq_x", 32'(sq_x), 304);
    check("reset_sq_y", 32'(sq_y), 224);
    check("reset_tick", 32'(frame_tick), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First frame after reset: no tick until address leaves 0.
    run_frame(8, 4'd0, 4'd0, 0, 0, 0, 1);
    // Down pressed only in the frame-start detect cycle -> sq_y 228.
    run_frame(8, B_DOWN, 4'd0, 0, 0, 0, 1);
    // Opposing left+right in one frame -> no horizontal change.
    run_frame(10, 4'd0, B_LEFT | B_RIGHT, 3, 6, 0, 1);
    // Right for 3 cycles mid-frame -> sq_x 308 after next frame start.
    run_frame(10, 4'd0, B_RIGHT, 4, 7, 0, 1);
    // Up held for 60 frames -> sq_y clamps at 0.
    for (int i = 0; i < 60; i++) run_frame(4, B_UP, B_UP, 0, 5, 0, 1);
    // Render 33 full lines with the square at (308,0), with a held address.
    run_frame(H * 33 - 1, 4'd0, 4'd0, 0, 0, $urandom_range(1, H * 33 - 2), 1);
    // Right held for 80 frames -> sq_x clamps at 608.
    for (int i = 0; i < 80; i++) run_frame(4, B_RIGHT, B_RIGHT, 0, 5, 0, 1);
    // Two lines: x=639 is square, line wrap at 639->640, hold at x=639.
    run_frame(1300, 4'd0, 4'd0, 0, 0, 639, 1);
    // Random button activity over short frames.
    for (int i = 0; i < 30; i++) begin
      rz  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      rb  = 4'($urandom_range(0, 15));
      len = $urandom_range(2, 40);
      p0  = $urandom_range(0, len);
      p1  = $urandom_range(p0, len + 1);
      run_frame(len, rz, rb, p0, p1, $urandom_range(0, len), 1);
    end
    run_frame(8, 4'd0, 4'd0, 0, 0, 0, 1);

    // Reset in the middle of a frame.
    for (int a = 149998; a <= 150000; a++) drive(a, 4'd0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    rgb_q.delete();
    tick_q.delete();
    sq_q.delete();
    model_reset();
    #1;
    check("midreset_rgb", 32'(rgb), 0);
    check("midreset_sq_x", 32'(sq_x), 304);
    check("midreset_sq_y", 32'(sq_y), 224);
    check("midreset_tick", 32'(frame_tick), 0);
    @(negedge clk);
    addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive(0, 4'd0, 0);
    run_frame(12, 4'd0, B_DOWN, 2, 4, 0, 1);
    run_frame(6, 4'd0, 4'd0, 0, 0, 0, 1);
    drive(0, 4'd0, 0);
    drive(0, 4'd0, 0);

    repeat (4) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(rgb_q.size() + tick_q.size() + sq_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
